button_event_decoder: RTL and testbench

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/button_event_decoder_pkg.sv | 27 ++
 rtl/button_event_fsm.sv | 74 +++++++
 rtl/button_event_decoder.sv | 88 ++++++++
 tb/tb_button_event_decoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_decoder_pkg.sv
// Shared types for the button event decoder: channel state, hold-count width, event bundle.
package button_event_decoder_pkg;

  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_e;

  typedef struct packed {
    logic press;
    logic rls;
    logic lng;
    logic rpt;
    logic held;
  } btn_evt_t;

  // Widened compare so cnt = 255 still reaches any nonzero threshold.
  function automatic logic reached(input logic [HOLD_W-1:0] cnt,
                                   input logic [HOLD_W-1:0] thr);
    return (thr != '0) &&
           (({1'b0, cnt} + (HOLD_W+1)'(1)) >= {1'b0, thr});
  endfunction

endpackage

// File: rtl/button_event_fsm.sv
// One button channel: IDLE/PRESSED/HELD with saturating hold counter.
// Latency 1 cycle from registered level to registered event; no backpressure.
module button_event_fsm
  import button_event_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              btn,
  input  logic              tick,
  input  logic [HOLD_W-1:0] long_count,
  input  logic [HOLD_W-1:0] repeat_count,
  output btn_evt_t          evt
);

  btn_state_e        state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d, cnt_inc;
  btn_evt_t          evt_q, evt_d;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + HOLD_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (btn) begin
          state_d     = ST_PRESSED;
          cnt_d       = '0;
          evt_d.press = 1'b1;
        end
      end
      ST_PRESSED, ST_HELD: begin
        // Release has priority over a threshold reached in the same cycle.
        if (!btn) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          evt_d.rls = 1'b1;
        end else if (tick) begin
          if (state_q == ST_PRESSED && reached(cnt_q, long_count)) begin
            state_d   = ST_HELD;
            cnt_d     = '0;
            evt_d.lng = 1'b1;
          end else if (state_q == ST_HELD && reached(cnt_q, repeat_count)) begin
            cnt_d     = '0;
            evt_d.rpt = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    evt_d.held = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  assign evt = evt_q;

endmodule

// File: rtl/button_event_decoder.sv
// Decodes debounced buttons into press/release/long/repeat pulses and a held level.
// Latency 2 cycles from input register to outputs; no backpressure.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int NBTN   = 5,
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NBTN-1:0]   btnDb,
  input  logic [TICK_W-1:0] tickDiv,
  input  logic [7:0]        longCount,
  input  logic [7:0]        repeatCount,
  output logic [NBTN-1:0]   btnPress,
  output logic [NBTN-1:0]   btnRelease,
  output logic [NBTN-1:0]   btnLong,
  output logic [NBTN-1:0]   btnRepeat,
  output logic [NBTN-1:0]   btnHeld
);

  logic [NBTN-1:0]   btn_reg_q, btn_reg_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic              tick;
  btn_evt_t          evt [NBTN];

  logic [NBTN-1:0] press_q, press_d, rls_q, rls_d, lng_q, lng_d;
  logic [NBTN-1:0] rpt_q, rpt_d, held_q, held_d;

  // >= keeps the prescaler bounded if tickDiv is lowered while counting.
  assign tick      = (presc_q >= tickDiv);
  assign presc_d   = tick ? '0 : presc_q + TICK_W'(1);
  assign btn_reg_d = btnDb;

  for (genvar i = 0; i < NBTN; i++) begin : g_ch
    button_event_fsm u_fsm (
      .clk          (clk),
      .rst          (rst),
      .btn          (btn_reg_q[i]),
      .tick         (tick),
      .long_count   (longCount),
      .repeat_count (repeatCount),
      .evt          (evt[i])
    );
  end

  always_comb begin
    press_d = '0;
    rls_d   = '0;
    lng_d   = '0;
    rpt_d   = '0;
    held_d  = '0;
    for (int i = 0; i < NBTN; i++) begin
      press_d[i] = evt[i].press;
      rls_d[i]   = evt[i].rls;
      lng_d[i]   = evt[i].lng;
      rpt_d[i]   = evt[i].rpt;
      held_d[i]  = evt[i].held;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_reg_q <= '0;
      presc_q   <= '0;
      press_q   <= '0;
      rls_q     <= '0;
      lng_q     <= '0;
      rpt_q     <= '0;
      held_q    <= '0;
    end else begin
      btn_reg_q <= btn_reg_d;
      presc_q   <= presc_d;
      press_q   <= press_d;
      rls_q     <= rls_d;
      lng_q     <= lng_d;
      rpt_q     <= rpt_d;
      held_q    <= held_d;
    end
  end

  assign btnPress   = press_q;
  assign btnRelease = rls_q;
  assign btnLong    = lng_q;
  assign btnRepeat  = rpt_q;
  assign btnHeld    = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Randomized and directed bench for button_event_decoder against a tick-counting reference model.
module tb_button_event_decoder;

  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btnDb;
  logic [15:0]   tickDiv;
  logic [7:0]    longCount, repeatCount;
  logic [NB-1:0] btnPress, btnRelease, btnLong, btnRepeat, btnHeld;

  button_event_decoder #(.NBTN(NB), .TICK_W(16)) dut (
    .clk(clk), .rst(rst), .btnDb(btnDb), .tickDiv(tickDiv),
    .longCount(longCount), .repeatCount(repeatCount),
    .btnPress(btnPress), .btnRelease(btnRelease), .btnLong(btnLong),
    .btnRepeat(btnRepeat), .btnHeld(btnHeld)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: per channel, "active" since press, whether the long
  // event has happened, and ticks elapsed since the last event.
  bit            m_act   [NB];
  bit            m_ldone [NB];
  int            m_since [NB];
  logic [NB-1:0] m_prev = '0;
  int            m_presc = 0;
  logic [NB-1:0] e_press = '0, e_rls = '0, e_lng = '0, e_rpt = '0, e_held = '0;

  // Pulse log for one watched channel: kind 0 press, 1 release, 2 long, 3 repeat.
  int wch = 0;
  int mark = 0;
  int lg [4][16];
  int ln [4];
  int hc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int lat(input int k, input int i);
    return (ln[k] > i) ? lg[k][i] : -1;
  endfunction

  task automatic start_log(input int ch);
    wch  = ch;
    mark = cyc + 1;
    hc   = 0;
    for (int k = 0; k < 4; k++) ln[k] = 0;
  endtask

  task automatic rec(input int k);
    if (ln[k] < 16) lg[k][ln[k]] = cyc - mark;
    ln[k]++;
  endtask

  task automatic step(input logic [NB-1:0] b, input logic r);
    logic          tk;
    logic [NB-1:0] n_press, n_rls, n_lng, n_rpt, n_held;
    btnDb = b;
    rst   = r;
    @(posedge clk);
    #1;
    cyc++;
    chk("press",   32'(btnPress),   r ? 32'd0 : 32'(e_press));
    chk("release", 32'(btnRelease), r ? 32'd0 : 32'(e_rls));
    chk("long",    32'(btnLong),    r ? 32'd0 : 32'(e_lng));
    chk("repeat",  32'(btnRepeat),  r ? 32'd0 : 32'(e_rpt));
    chk("held",    32'(btnHeld),    r ? 32'd0 : 32'(e_held));
    if (btnPress[wch])   rec(0);
    if (btnRelease[wch]) rec(1);
    if (btnLong[wch])    rec(2);
    if (btnRepeat[wch])  rec(3);
    if (btnHeld[wch])    hc++;

    n_press = '0; n_rls = '0; n_lng = '0; n_rpt = '0; n_held = '0;
    if (r) begin
      for (int c = 0; c < NB; c++) begin
        m_act[c] = 0; m_ldone[c] = 0; m_since[c] = 0;
      end
      m_prev  = '0;
      m_presc = 0;
    end else begin
      tk      = (m_presc >= int'(tickDiv));
      m_presc = tk ? 0 : m_presc + 1;
      for (int c = 0; c < NB; c++) begin
        if (!m_act[c] && m_prev[c]) begin
          m_act[c] = 1; m_ldone[c] = 0; m_since[c] = 0; n_press[c] = 1'b1;
        end else if (m_act[c] && !m_prev[c]) begin
          m_act[c] = 0; n_rls[c] = 1'b1;
        end else if (m_act[c] && tk) begin
          m_since[c]++;
          if (!m_ldone[c]) begin
            if (longCount != 0 && m_since[c] >= int'(longCount)) begin
              m_ldone[c] = 1; m_since[c] = 0; n_lng[c] = 1'b1;
            end
          end else if (repeatCount != 0 && m_since[c] >= int'(repeatCount)) begin
            m_since[c] = 0; n_rpt[c] = 1'b1;
          end
        end
        n_held[c] = m_act[c];
      end
      m_prev = b;
    end
    e_press = n_press; e_rls = n_rls; e_lng = n_lng; e_rpt = n_rpt; e_held = n_held;
  endtask

  task automatic cfg(input int td, input int lc, input int rc);
    tickDiv     = 16'(td);
    longCount   = 8'(lc);
    repeatCount = 8'(rc);
  endtask

  initial begin
    logic [NB-1:0] b;
    logic          r;
    for (int c = 0; c < NB; c++) begin
      m_act[c] = 0; m_ldone[c] = 0; m_since[c] = 0;
    end
    btnDb = '0;
    rst   = 1'b1;
    cfg(0, 0, 0);
    step('0, 1'b1);
    step('0, 1'b1);

    // Short hold with tick every cycle: press, long, repeats, release.
    cfg(0, 3, 2);
    start_log(0);
    repeat (10) step(5'b00001, 1'b0);
    repeat (6)  step(5'b00000, 1'b0);
    chk("t29_press_at",   32'(lat(0, 0)), 32'd2);
    chk("t29_long_at",    32'(lat(2, 0)), 32'd5);
    chk("t29_rep0_at",    32'(lat(3, 0)), 32'd7);
    chk("t29_rep1_at",    32'(lat(3, 1)), 32'd9);
    chk("t29_release_at", 32'(lat(1, 0)), 32'd12);

    // Long press disabled over a 300-cycle hold.
    cfg(0, 0, 2);
    start_log(2);
    repeat (300) step(5'b00100, 1'b0);
    repeat (6)   step(5'b00000, 1'b0);
    chk("t30_presses",  32'(ln[0]), 32'd1);
    chk("t30_releases", 32'(ln[1]), 32'd1);
    chk("t30_longs",    32'(ln[2]), 32'd0);
    chk("t30_repeats",  32'(ln[3]), 32'd0);
    chk("t30_held_cyc", 32'(hc),    32'd300);

    // Release on the exact cycle long would fire, then the control case one cycle later.
    cfg(3, 2, 0);
    step('0, 1'b1);
    start_log(0);
    repeat (6) step(5'b00001, 1'b0);
    repeat (6) step(5'b00000, 1'b0);
    chk("t31_longs",      32'(ln[2]),     32'd0);
    chk("t31_release_at", 32'(lat(1, 0)), 32'd8);
    step('0, 1'b1);
    start_log(0);
    repeat (7) step(5'b00001, 1'b0);
    repeat (6) step(5'b00000, 1'b0);
    chk("t31c_long_at", 32'(lat(2, 0)), 32'd8);

    // Staggered overlapping presses on all channels.
    cfg(1, 3, 2);
    step('0, 1'b1);
    start_log(4);
    for (int t = 0; t < 50; t++) begin
      b = '0;
      for (int c = 0; c < NB; c++)
        if (t >= 3 * c && t < 3 * c + 15 + 2 * c) b[c] = 1'b1;
      step(b, 1'b0);
    end
    chk("t32_ch4_presses",  32'(ln[0]), 32'd1);
    chk("t32_ch4_releases", 32'(ln[1]), 32'd1);

    // Reset while held: no release, fresh press afterwards.
    cfg(0, 2, 3);
    step('0, 1'b1);
    start_log(1);
    repeat (8) step(5'b00010, 1'b0);
    chk("t33_long_before", 32'(ln[2]), 32'd1);
    step(5'b00010, 1'b1);
    start_log(1);
    repeat (6) step(5'b00010, 1'b0);
    chk("t33_press_at",    32'(lat(0, 0)), 32'd2);
    chk("t33_no_release",  32'(ln[1]),     32'd0);
    repeat (4) step('0, 1'b0);

    // Lower repeatCount below the running count while held.
    cfg(0, 1, 20);
    step('0, 1'b1);
    start_log(3);
    repeat (13) step(5'b01000, 1'b0);
    repeatCount = 8'd4;
    repeat (8) step(5'b01000, 1'b0);
    repeat (4) step('0, 1'b0);
    chk("t34_long_at", 32'(lat(2, 0)), 32'd3);
    chk("t34_rep0_at", 32'(lat(3, 0)), 32'd14);
    chk("t34_rep1_at", 32'(lat(3, 1)), 32'd18);

    // Random traffic with live parameter changes and occasional resets.
    b = '0;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(39, 0) == 0)
        cfg($urandom_range(3, 0), $urandom_range(6, 0), $urandom_range(4, 0));
      for (int c = 0; c < NB; c++)
        if ($urandom_range(11, 0) == 0) b[c] = ~b[c];
      r = ($urandom_range(299, 0) == 0);
      step(b, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
